// File: rtl/ioctl_upload_server.sv
// Serves HPS ioctl upload reads for one save slot from a 16-bit backing memory,
// with out-of-range fill, a bounded wait for read data and a sticky timeout flag.
module ioctl_upload_server #(
  parameter logic [7:0] INDEX      = 8'd2,
  parameter int         ADDR_WIDTH = 16,
  parameter int         SIZE_WORDS = 32768,
  parameter int         TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ioctl_upload,
  input  logic                  ioctl_rd,
  input  logic [7:0]            ioctl_index,
  input  logic [26:0]           ioctl_addr,
  output logic [15:0]           ioctl_din,
  output logic                  ioctl_wait,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_waitReq,
  input  logic [15:0]           mem_data,
  input  logic                  mem_valid,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] SIZE_LIM  = (ADDR_WIDTH + 1)'(SIZE_WORDS);
  localparam logic [7:0]          COUNT_END = 8'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic                  mem_rd_reg, mem_rd_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]           din_reg, din_next;
  logic                  error_reg, error_next;
  logic [7:0]            count_reg, count_next;

  logic                  selected;
  logic                  in_range;
  logic                  accept;
  logic                  timeout;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Bit 0 is always zero (even byte address); upper bits lie outside the slot.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ioctl_addr[26:ADDR_WIDTH+1], ioctl_addr[0]};

  assign word_addr = ioctl_addr[ADDR_WIDTH:1];
  assign selected  = ioctl_upload & ioctl_rd & (ioctl_index == INDEX);
  assign in_range  = {1'b0, word_addr} < SIZE_LIM;
  assign accept    = mem_rd_reg & ~mem_waitReq;
  // Fires in the cycle the counter steps onto TIMEOUT.
  assign timeout   = (count_reg == COUNT_END);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      mem_rd_reg <= 1'b0;
      addr_reg   <= '0;
      din_reg    <= 16'h0000;
      error_reg  <= 1'b0;
      count_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      mem_rd_reg <= mem_rd_next;
      addr_reg   <= addr_next;
      din_reg    <= din_next;
      error_reg  <= error_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_rd_next = mem_rd_reg;
    addr_next   = addr_reg;
    din_next    = din_reg;
    error_next  = error_reg;
    count_next  = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (selected) begin
          if (in_range) begin
            addr_next   = word_addr;
            mem_rd_next = 1'b1;
            count_next  = 8'd0;
            state_next  = REQ;
          end else begin
            din_next = 16'hFFFF;
          end
        end
      end
      REQ: begin
        count_next = count_reg + 8'd1;
        // An accept in the same cycle still owes us a mem_valid, so drain it.
        if (!ioctl_upload) begin
          mem_rd_next = 1'b0;
          state_next  = accept ? DRAIN : IDLE;
        end else if (timeout) begin
          din_next    = 16'hFFFF;
          error_next  = 1'b1;
          mem_rd_next = 1'b0;
          state_next  = accept ? DRAIN : IDLE;
        end else if (accept) begin
          mem_rd_next = 1'b0;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        count_next = count_reg + 8'd1;
        if (!ioctl_upload) begin
          state_next = mem_valid ? IDLE : DRAIN;
        end else if (mem_valid) begin
          din_next   = {mem_data[7:0], mem_data[15:8]};
          state_next = IDLE;
        end else if (timeout) begin
          din_next   = 16'hFFFF;
          error_next = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ioctl_wait = (selected & (state_reg == IDLE)) | (state_reg == REQ) | (state_reg == WAIT);
  assign ioctl_din  = din_reg;
  assign mem_rd     = mem_rd_reg;
  assign mem_addr   = addr_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed bench for ioctl_upload_server: inputs change on the falling edge,
// outputs are checked just after, one line printed per transaction.
module tb_ioctl_upload_server;

  logic        clock = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_waitReq;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  ioctl_upload_server dut (
    .clock       (clock),
    .reset       (reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd    (ioctl_rd),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_waitReq (mem_waitReq),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; mem_waitReq = 1'b0; mem_data = '0; mem_valid = 1'b0;
    step(); step();
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_din", 32'(ioctl_din), 0);
    check("rst_error", 32'(error), 0);
    check("rst_wait", 32'(ioctl_wait), 0);
    reset = 1'b0;
    ioctl_upload = 1'b1; ioctl_index = 8'd2;
    step();

    // Basic read of byte address 0x10, data three cycles after accept
    ioctl_rd = 1'b1; ioctl_addr = 27'h10; #1;
    check("t1_wait_strobe", 32'(ioctl_wait), 1);
    step(); ioctl_rd = 1'b0; #1;
    check("t1_mem_rd", 32'(mem_rd), 1);
    check("t1_mem_addr", 32'(mem_addr), 32'h8);
    check("t1_wait_req", 32'(ioctl_wait), 1);
    step();
    check("t1_mem_rd_clr", 32'(mem_rd), 0);
    check("t1_wait_w1", 32'(ioctl_wait), 1);
    step();
    check("t1_wait_w2", 32'(ioctl_wait), 1);
    step(); mem_valid = 1'b1; mem_data = 16'h1234; #1;
    check("t1_wait_valid", 32'(ioctl_wait), 1);
    step(); mem_valid = 1'b0; #1;
    check("t1_din", 32'(ioctl_din), 32'h3412);
    check("t1_wait_done", 32'(ioctl_wait), 0);
    $display("txn1 read addr 0x10 din=%h", ioctl_din);

    // Memory stalls with waitReq for 5 cycles
    mem_waitReq = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 27'h20;
    step(); ioctl_rd = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      check("t2_mem_rd_hold", 32'(mem_rd), 1);
      check("t2_mem_addr_hold", 32'(mem_addr), 32'h10);
      step();
    end
    mem_waitReq = 1'b0; #1;
    check("t2_mem_rd_last", 32'(mem_rd), 1);
    step();
    check("t2_mem_rd_accepted", 32'(mem_rd), 0);
    check("t2_wait", 32'(ioctl_wait), 1);
    mem_valid = 1'b1; mem_data = 16'hBEEF;
    step(); mem_valid = 1'b0; #1;
    check("t2_din", 32'(ioctl_din), 32'hEFBE);
    check("t2_mem_rd_single", 32'(mem_rd), 0);
    check("t2_wait_done", 32'(ioctl_wait), 0);
    $display("txn2 stalled read addr 0x20 din=%h", ioctl_din);

    // Out-of-range address
    ioctl_rd = 1'b1; ioctl_addr = 27'h10000; #1;
    check("t3_wait_strobe", 32'(ioctl_wait), 1);
    step(); ioctl_rd = 1'b0; #1;
    check("t3_din", 32'(ioctl_din), 32'hFFFF);
    check("t3_mem_rd", 32'(mem_rd), 0);
    check("t3_wait_after", 32'(ioctl_wait), 0);
    $display("txn3 out-of-range din=%h", ioctl_din);

    // Wrong index is ignored
    ioctl_index = 8'd3; ioctl_rd = 1'b1; ioctl_addr = 27'h10; #1;
    check("t4_wait", 32'(ioctl_wait), 0);
    step(); ioctl_rd = 1'b0; #1;
    check("t4_mem_rd", 32'(mem_rd), 0);
    check("t4_din", 32'(ioctl_din), 32'hFFFF);
    ioctl_index = 8'd2;
    $display("txn4 index 3 ignored");

    // Memory never answers: timeout after 255 cycles
    ioctl_din_mark: begin end
    mem_data = 16'h0000;
    ioctl_rd = 1'b1; ioctl_addr = 27'h40;
    step(); ioctl_rd = 1'b0;
    for (int i = 0; i < 250; i++) step();
    check("t5_error_early", 32'(error), 0);
    check("t5_wait_early", 32'(ioctl_wait), 1);
    for (int i = 0; i < 10; i++) step();
    check("t5_error", 32'(error), 1);
    check("t5_din", 32'(ioctl_din), 32'hFFFF);
    check("t5_wait_drain", 32'(ioctl_wait), 0);
    check("t5_mem_rd", 32'(mem_rd), 0);
    ioctl_rd = 1'b1; #1;
    check("t5_drain_strobe", 32'(ioctl_wait), 0);
    step(); ioctl_rd = 1'b0;
    mem_valid = 1'b1; mem_data = 16'hABCD;
    step(); mem_valid = 1'b0; #1;
    check("t5_late_din", 32'(ioctl_din), 32'hFFFF);
    $display("txn5 timeout error=%0d din=%h", error, ioctl_din);

    // Upload drops while waiting for data
    ioctl_rd = 1'b1; ioctl_addr = 27'h2; #1;
    check("t6_wait_strobe", 32'(ioctl_wait), 1);
    step(); ioctl_rd = 1'b0;
    step();
    ioctl_upload = 1'b0; #1;
    check("t6_wait_in_wait", 32'(ioctl_wait), 1);
    step(); #1;
    check("t6_wait_dropped", 32'(ioctl_wait), 0);
    check("t6_din_kept", 32'(ioctl_din), 32'hFFFF);
    ioctl_upload = 1'b1; ioctl_rd = 1'b1; #1;
    check("t6_drain_strobe", 32'(ioctl_wait), 0);
    step(); ioctl_rd = 1'b0; #1;
    check("t6_wait_low", 32'(ioctl_wait), 0);
    mem_valid = 1'b1; mem_data = 16'h5555;
    step(); mem_valid = 1'b0; #1;
    check("t6_discard", 32'(ioctl_din), 32'hFFFF);
    ioctl_rd = 1'b1; ioctl_addr = 27'h4; #1;
    check("t6_next_wait", 32'(ioctl_wait), 1);
    step(); ioctl_rd = 1'b0; #1;
    check("t6_next_addr", 32'(mem_addr), 32'h2);
    step();
    mem_valid = 1'b1; mem_data = 16'h0102;
    step(); mem_valid = 1'b0; #1;
    check("t6_next_din", 32'(ioctl_din), 32'h0201);
    check("t6_error_sticky", 32'(error), 1);
    $display("txn6 abort then read addr 0x4 din=%h", ioctl_din);

    // Reset in the middle of a request
    ioctl_rd = 1'b1; ioctl_addr = 27'h8;
    step(); ioctl_rd = 1'b0; reset = 1'b1;
    step(); reset = 1'b0; #1;
    check("t7_error", 32'(error), 0);
    check("t7_mem_rd", 32'(mem_rd), 0);
    check("t7_din", 32'(ioctl_din), 0);
    check("t7_wait", 32'(ioctl_wait), 0);
    mem_valid = 1'b1; mem_data = 16'h7777;
    step(); mem_valid = 1'b0; #1;
    check("t7_valid_ignored", 32'(ioctl_din), 0);
    $display("txn7 reset mid-request din=%h", ioctl_din);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
